// File: rtl/weight_row_streamer_if.sv
// Host-load and consumer-read ports of the weight row streamer.
// Handshake: a word moves on a rising edge only when its valid and ready are both high;
// the producer holds data and valid stable until that edge, and ready never depends on valid.
interface weight_row_streamer_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_ROWS = 4
);
  localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              load_next_row;
  logic              rd_en;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [IDX_W-1:0]  row_idx;

  modport slave (
    input  w_valid, w_data, rd_en,
    output w_ready, load_next_row, rd_valid, rd_data, rd_last, row_idx
  );

  modport master (
    output w_valid, w_data, rd_en,
    input  w_ready, load_next_row, rd_valid, rd_data, rd_last, row_idx
  );
endinterface

// File: rtl/weight_row_streamer.sv
// Double-buffered weight-row streamer: requests rows from the host one at a time,
// loads them into two ping-pong banks and replays each row word by word to the MAC.
module weight_row_streamer #(
  parameter int DATA_W   = 16,
  parameter int ROW_LEN  = 8,
  parameter int NUM_ROWS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic layer_done,
  output logic dbg_state,
  weight_row_streamer_if.slave bus
);
  localparam int PTR_W = $clog2(ROW_LEN);
  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ROW_LEN - 1);
  localparam logic [CNT_W-1:0] ROWS     = CNT_W'(NUM_ROWS);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [2][ROW_LEN];
  logic [1:0]        bank_full, bank_full_nxt;
  logic              wr_bank, rd_bank;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  rows_req, rows_loaded, rows_read;
  logic              req_pulse;

  logic start_go, req_fire, pass_done;
  logic wr_fire, wr_row_done, rd_fire, rd_row_done;

  assign bus.w_ready       = (state == RUN) && (rows_loaded < rows_req) && !bank_full[wr_bank];
  assign bus.rd_valid      = bank_full[rd_bank];
  assign bus.rd_data       = mem[rd_bank][rd_ptr];
  assign bus.rd_last       = bus.rd_valid && (rd_ptr == LAST_PTR);
  assign bus.row_idx       = rows_read[IDX_W-1:0];
  assign bus.load_next_row = req_pulse;
  assign busy              = (state == RUN);
  assign dbg_state         = state;

  assign wr_fire     = bus.w_valid && bus.w_ready;
  assign wr_row_done = wr_fire && (wr_ptr == LAST_PTR);
  assign rd_fire     = bus.rd_en && bus.rd_valid;
  assign rd_row_done = rd_fire && (rd_ptr == LAST_PTR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A request only goes out when the previous one has been fully loaded, so at most one is outstanding.
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    req_fire  = 1'b0;
    pass_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          start_go  = 1'b1;
        end
      end
      RUN: begin
        req_fire = (rows_req < ROWS) && (rows_req == rows_loaded) && !bank_full[wr_bank];
        if (rd_row_done && (rows_read == LAST_ROW)) begin
          pass_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill and free always target different banks, so both may land on one edge.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_row_done) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_row_done) bank_full_nxt[rd_bank] = 1'b0;
    if (start_go)    bank_full_nxt = 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_full   <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rows_req    <= '0;
      rows_loaded <= '0;
      rows_read   <= '0;
      req_pulse   <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      bank_full  <= bank_full_nxt;
      req_pulse  <= req_fire;
      layer_done <= pass_done;
      if (start_go) begin
        wr_bank     <= 1'b0;
        rd_bank     <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        rows_req    <= '0;
        rows_loaded <= '0;
        rows_read   <= '0;
      end else begin
        if (req_fire) rows_req <= rows_req + CNT_W'(1);
        if (wr_fire) begin
          if (wr_row_done) begin
            wr_ptr      <= '0;
            wr_bank     <= ~wr_bank;
            rows_loaded <= rows_loaded + CNT_W'(1);
          end else begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
        end
        if (rd_fire) begin
          if (rd_row_done) begin
            rd_ptr    <= '0;
            rd_bank   <= ~rd_bank;
            rows_read <= rows_read + CNT_W'(1);
          end else begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
        end
      end
    end
  end

  // Bank storage carries no reset; contents are only meaningful once bank_full says so.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_ptr] <= bus.w_data;
  end
endmodule

// File: tb/tb_weight_row_streamer.sv
// Self-checking bench for weight_row_streamer: host/consumer drivers, a word-order
// scoreboard and per-scenario tasks with inline timing and protocol comparisons.
module tb_weight_row_streamer;
  localparam int DATA_W   = 16;
  localparam int ROW_LEN  = 4;
  localparam int NUM_ROWS = 3;
  localparam int IDX_W    = 2;
  localparam int WORDS    = ROW_LEN * NUM_ROWS;
  localparam int BIG      = 1 << 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, layer_done, dbg_state;

  always #5 clk = ~clk;

  weight_row_streamer_if #(.DATA_W(DATA_W), .NUM_ROWS(NUM_ROWS)) bus ();

  weight_row_streamer #(.DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .NUM_ROWS(NUM_ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .layer_done (layer_done),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  // ---------------- bench state / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] src_q[$];
  int pulse_acc[$];
  int pulse_reads[$];
  int words_allowed, pulses, dones, reads, accepted;
  int host_limit, rd_limit, wv_pct, rd_pct;
  bit host_early, wr_pending, busy_at_done_bad;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic bench_clear();
    src_q.delete(); exp_q.delete(); pulse_acc.delete(); pulse_reads.delete();
    words_allowed = 0; pulses = 0; dones = 0; reads = 0; accepted = 0;
    host_limit = BIG; rd_limit = BIG; wv_pct = 100; rd_pct = 100;
    host_early = 1'b0; wr_pending = 1'b0; busy_at_done_bad = 1'b0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.rd_en = 1'b0;
  endtask

  task automatic load_words(input bit rand_data);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < WORDS; i++) begin
      w = rand_data ? DATA_W'($urandom) : DATA_W'(i + 1);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  // One cycle: account for the previous edge, then drive host and consumer for the next edge.
  task automatic tick();
    logic [DATA_W-1:0] w;
    @(negedge clk);
    if (wr_pending) begin
      w = src_q.pop_front();
      accepted++; words_allowed--;
      bus.w_valid = 1'b0; wr_pending = 1'b0;
    end
    if (bus.load_next_row === 1'b1) begin
      pulses++; words_allowed += ROW_LEN;
      pulse_acc.push_back(accepted); pulse_reads.push_back(reads);
    end
    if (layer_done === 1'b1) begin
      dones++;
      if (busy !== 1'b0) busy_at_done_bad = 1'b1;
    end
    if (!bus.w_valid && src_q.size() > 0 && accepted < host_limit &&
        (words_allowed > 0 || host_early) && $urandom_range(0, 99) < wv_pct) begin
      bus.w_valid = 1'b1;
      bus.w_data  = src_q[0];
    end
    wr_pending = bus.w_valid && (bus.w_ready === 1'b1);
    bus.rd_en = (reads < rd_limit) && ($urandom_range(0, 99) < rd_pct);
    if (bus.rd_valid !== 1'b1 && bus.rd_last !== 1'b0) begin
      n_tests++; n_fail++;
      $display("FAIL rd_last_idle: rd_last=%b while rd_valid=%b, required 0", bus.rd_last, bus.rd_valid);
    end
    if (bus.rd_en && bus.rd_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_underflow: read %0d got %h, required no further data", reads, bus.rd_data);
      end else begin
        w = exp_q.pop_front();
        if (bus.rd_data !== w || bus.rd_last !== ((reads % ROW_LEN) == ROW_LEN - 1) ||
            bus.row_idx !== IDX_W'(reads / ROW_LEN)) begin
          n_fail++;
          $display("FAIL rd_word[%0d]: got data=%h last=%b row=%0d, required data=%h last=%b row=%0d",
                   reads, bus.rd_data, bus.rd_last, bus.row_idx, w,
                   ((reads % ROW_LEN) == ROW_LEN - 1), reads / ROW_LEN);
        end
      end
      reads++;
    end
  endtask

  task automatic do_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (dones > 0) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    bench_clear();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.w_ready, bus.load_next_row, bus.rd_valid, bus.rd_last, layer_done, busy} !== 6'b0 ||
        bus.row_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_values: w_ready=%b lnr=%b rd_valid=%b rd_last=%b done=%b busy=%b row=%0d, required all 0",
               bus.w_ready, bus.load_next_row, bus.rd_valid, bus.rd_last, layer_done, busy, bus.row_idx);
    end
    reset = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (busy !== 1'b0 || pulses != 0 || bus.w_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: busy=%b pulses=%0d w_ready=%b, required 0/0/0", busy, pulses, bus.w_ready);
    end
  endtask

  task automatic test_basic_pass();
    bit ok, early;
    bench_clear(); load_words(1'b0);
    do_start();
    n_tests++;
    if (busy !== 1'b1 || bus.w_ready !== 1'b0 || bus.load_next_row !== 1'b0) begin
      n_fail++;
      $display("FAIL start_e0: busy=%b w_ready=%b lnr=%b, required 1/0/0", busy, bus.w_ready, bus.load_next_row);
    end
    tick();
    n_tests++;
    if (bus.load_next_row !== 1'b1 || bus.w_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_e1: lnr=%b w_ready=%b, required 1/1", bus.load_next_row, bus.w_ready);
    end
    tick();
    n_tests++;
    if (bus.load_next_row !== 1'b0) begin
      n_fail++;
      $display("FAIL start_e2: lnr=%b, required 0", bus.load_next_row);
    end
    early = 1'b0;
    for (int i = 0; i < 20 && accepted < ROW_LEN; i++) begin
      tick();
      if (accepted < ROW_LEN && bus.rd_valid !== 1'b0) early = 1'b1;
    end
    n_tests++;
    if (early || bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0001 || bus.load_next_row !== 1'b0) begin
      n_fail++;
      $display("FAIL row0_latency: early=%b rd_valid=%b data=%h lnr=%b, required 0/1/0001/0",
               early, bus.rd_valid, bus.rd_data, bus.load_next_row);
    end
    tick();
    n_tests++;
    if (bus.load_next_row !== 1'b1) begin
      n_fail++;
      $display("FAIL next_request: lnr=%b one edge after row 0 fill, required 1", bus.load_next_row);
    end
    wait_done(200, ok);
    repeat (3) tick();
    n_tests++;
    if (!ok || pulses != NUM_ROWS || reads != WORDS || dones != 1 || exp_q.size() != 0 ||
        busy !== 1'b0 || busy_at_done_bad) begin
      n_fail++;
      $display("FAIL basic_end: ok=%b pulses=%0d reads=%0d dones=%0d left=%0d busy=%b bad=%b, required 1/%0d/%0d/1/0/0/0",
               ok, pulses, reads, dones, exp_q.size(), busy, busy_at_done_bad, NUM_ROWS, WORDS);
    end
  endtask

  task automatic test_overlap();
    bit ok, bad_order;
    bench_clear(); load_words(1'b1);
    rd_limit = 0;
    do_start();
    repeat (40) tick();
    n_tests++;
    if (pulses != 2 || accepted != 2 * ROW_LEN || bus.w_ready !== 1'b0 || bus.rd_valid !== 1'b1 ||
        bus.rd_data !== exp_q[0] || bus.row_idx !== '0) begin
      n_fail++;
      $display("FAIL overlap_stall: pulses=%0d acc=%0d w_ready=%b rd_valid=%b data=%h row=%0d, required 2/%0d/0/1/%h/0",
               pulses, accepted, bus.w_ready, bus.rd_valid, bus.rd_data, bus.row_idx, 2 * ROW_LEN, exp_q[0]);
    end
    rd_limit = BIG; rd_pct = 60; wv_pct = 70;
    wait_done(400, ok);
    bad_order = 1'b0;
    for (int k = 0; k < pulse_acc.size(); k++) begin
      if (pulse_acc[k] < k * ROW_LEN) bad_order = 1'b1;
      if (k >= 2 && pulse_reads[k] < (k - 1) * ROW_LEN) bad_order = 1'b1;
    end
    n_tests++;
    if (!ok || bad_order || pulses != NUM_ROWS || reads != WORDS || dones != 1 || exp_q.size() != 0 ||
        busy_at_done_bad) begin
      n_fail++;
      $display("FAIL overlap_end: ok=%b order_bad=%b pulses=%0d reads=%0d dones=%0d left=%0d, required 1/0/%0d/%0d/1/0",
               ok, bad_order, pulses, reads, dones, exp_q.size(), NUM_ROWS, WORDS);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bench_clear(); load_words(1'b1);
    src_q[0] = 16'hAAAA; exp_q[0] = 16'hAAAA;
    host_early = 1'b1;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (bus.w_ready !== 1'b0 || accepted != 0 || bus.w_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_idle: w_ready=%b accepted=%0d, required 0/0", bus.w_ready, accepted);
    end
    do_start();
    tick();
    n_tests++;
    if (accepted != 0 || bus.w_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_e1: accepted=%0d w_ready=%b after E1, required 0/1", accepted, bus.w_ready);
    end
    tick();
    n_tests++;
    if (accepted != 1) begin
      n_fail++;
      $display("FAIL bp_e2: accepted=%0d after E2, required 1", accepted);
    end
    for (int i = 0; i < 30 && bus.rd_valid !== 1'b1; i++) tick();
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL bp_first_word: rd_valid=%b data=%h, required 1/aaaa", bus.rd_valid, bus.rd_data);
    end
    wait_done(200, ok);
    n_tests++;
    if (!ok || pulses != NUM_ROWS || reads != WORDS || dones != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_end: ok=%b pulses=%0d reads=%0d dones=%0d left=%0d, required 1/%0d/%0d/1/0",
               ok, pulses, reads, dones, exp_q.size(), NUM_ROWS, WORDS);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    bench_clear(); load_words(1'b1);
    host_limit = 2 * ROW_LEN - 1; rd_limit = 0;
    do_start();
    for (int i = 0; i < 60 && accepted < 2 * ROW_LEN - 1; i++) tick();
    repeat (3) tick();
    rd_limit = ROW_LEN - 1;
    for (int i = 0; i < 20 && reads < ROW_LEN - 1; i++) tick();
    repeat (2) tick();
    n_tests++;
    if (accepted != 2 * ROW_LEN - 1 || bus.w_ready !== 1'b1 || bus.rd_valid !== 1'b1 ||
        bus.rd_last !== 1'b1 || pulses != 2) begin
      n_fail++;
      $display("FAIL sim_setup: acc=%0d w_ready=%b rd_valid=%b rd_last=%b pulses=%0d, required %0d/1/1/1/2",
               accepted, bus.w_ready, bus.rd_valid, bus.rd_last, pulses, 2 * ROW_LEN - 1);
    end
    host_limit = 2 * ROW_LEN; rd_limit = ROW_LEN;
    tick();
    n_tests++;
    if (!wr_pending || reads != ROW_LEN) begin
      n_fail++;
      $display("FAIL sim_joint: write_now=%b reads=%0d, required 1/%0d", wr_pending, reads, ROW_LEN);
    end
    tick();
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0] || bus.row_idx !== IDX_W'(1) ||
        bus.rd_last !== 1'b0 || bus.w_ready !== 1'b0 || bus.load_next_row !== 1'b0 || accepted != 2 * ROW_LEN) begin
      n_fail++;
      $display("FAIL sim_after: rd_valid=%b data=%h row=%0d last=%b w_ready=%b lnr=%b acc=%0d, required 1/%h/1/0/0/0/%0d",
               bus.rd_valid, bus.rd_data, bus.row_idx, bus.rd_last, bus.w_ready, bus.load_next_row,
               accepted, exp_q[0], 2 * ROW_LEN);
    end
    tick();
    n_tests++;
    if (bus.load_next_row !== 1'b1 || bus.w_ready !== 1'b1 || pulses != 3) begin
      n_fail++;
      $display("FAIL sim_request: lnr=%b w_ready=%b pulses=%0d, required 1/1/3", bus.load_next_row, bus.w_ready, pulses);
    end
    tick();
    n_tests++;
    if (bus.load_next_row !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_single_pulse: lnr=%b, required 0", bus.load_next_row);
    end
    host_limit = BIG; rd_limit = BIG;
    wait_done(200, ok);
    n_tests++;
    if (!ok || pulses != NUM_ROWS || reads != WORDS || dones != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sim_end: ok=%b pulses=%0d reads=%0d dones=%0d left=%0d, required 1/%0d/%0d/1/0",
               ok, pulses, reads, dones, exp_q.size(), NUM_ROWS, WORDS);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bench_clear(); load_words(1'b1);
    rd_limit = ROW_LEN + 2;
    do_start();
    for (int i = 0; i < 60 && reads < ROW_LEN + 2; i++) tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.w_ready, bus.load_next_row, bus.rd_valid, bus.rd_last, layer_done, busy} !== 6'b0 ||
        bus.row_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: w_ready=%b lnr=%b rd_valid=%b rd_last=%b done=%b busy=%b row=%0d, required all 0",
               bus.w_ready, bus.load_next_row, bus.rd_valid, bus.rd_last, layer_done, busy, bus.row_idx);
    end
    bench_clear();
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (dones != 0 || pulses != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: dones=%0d pulses=%0d busy=%b, required 0/0/0", dones, pulses, busy);
    end
    load_words(1'b1);
    do_start();
    wait_done(200, ok);
    n_tests++;
    if (!ok || pulses != NUM_ROWS || reads != WORDS || dones != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_replay: ok=%b pulses=%0d reads=%0d dones=%0d left=%0d, required 1/%0d/%0d/1/0",
               ok, pulses, reads, dones, exp_q.size(), NUM_ROWS, WORDS);
    end
  endtask

  task automatic test_ignored_inputs();
    bit ok;
    bench_clear(); load_words(1'b1);
    host_limit = 0;
    do_start();
    repeat (6) tick();
    n_tests++;
    if (pulses != 1 || bus.rd_valid !== 1'b0 || bus.w_ready !== 1'b1 || bus.row_idx !== '0 || bus.rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_rd_en: pulses=%0d rd_valid=%b w_ready=%b row=%0d, required 1/0/1/0",
               pulses, bus.rd_valid, bus.w_ready, bus.row_idx);
    end
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (busy !== 1'b1 || pulses != 1 || bus.load_next_row !== 1'b0 || bus.w_ready !== 1'b1 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_start_early: busy=%b pulses=%0d lnr=%b w_ready=%b rd_valid=%b, required 1/1/0/1/0",
               busy, pulses, bus.load_next_row, bus.w_ready, bus.rd_valid);
    end
    host_limit = BIG; rd_limit = ROW_LEN + 1;
    for (int i = 0; i < 60 && reads < ROW_LEN + 1; i++) tick();
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    rd_limit = BIG;
    wait_done(200, ok);
    n_tests++;
    if (!ok || pulses != NUM_ROWS || reads != WORDS || dones != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ign_end: ok=%b pulses=%0d reads=%0d dones=%0d left=%0d, required 1/%0d/%0d/1/0",
               ok, pulses, reads, dones, exp_q.size(), NUM_ROWS, WORDS);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int p = 0; p < 4; p++) begin
      bench_clear(); load_words(1'b1);
      wv_pct = $urandom_range(30, 100);
      rd_pct = $urandom_range(30, 100);
      do_start();
      wait_done(600, ok);
      n_tests++;
      if (!ok || pulses != NUM_ROWS || reads != WORDS || dones != 1 || exp_q.size() != 0 ||
          busy !== 1'b0 || busy_at_done_bad) begin
        n_fail++;
        $display("FAIL b2b_pass%0d: ok=%b pulses=%0d reads=%0d dones=%0d left=%0d busy=%b, required 1/%0d/%0d/1/0/0",
                 p, ok, pulses, reads, dones, exp_q.size(), busy, NUM_ROWS, WORDS);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.w_valid = 1'b0; bus.w_data = '0; bus.rd_en = 1'b0;
    test_reset();
    test_basic_pass();
    test_overlap();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_ignored_inputs();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_row_streamer.md
# weight_row_streamer

Parametrised, double-buffered weight-row streamer for the layer datapath. It requests weight rows from the host one at a time with a `load_next_row` pulse and accepts each row over a valid/ready load port. It then replays each row, one weight per read, to the MAC consumer. Row length, row count and data width are generic, and loading of row N+1 overlaps consumption of row N.

## Interface
- `DATA_W`, 16: width of one weight.
- `ROW_LEN`, 8: weights per row; must be ≥ 2.
- `NUM_ROWS`, 4: rows per layer pass; must be ≥ 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: begins a layer pass; sampled only in IDLE.
- `w_valid`  in  1: host load word valid.
- `w_data`  in  DATA_W: host load word.
- `w_ready`  out  1: streamer accepts `w_data` this cycle.
- `load_next_row`  out  1: one-cycle pulse requesting the next row from the host.
- `rd_en`  in  1: consumer takes the current weight.
- `rd_valid`  out  1: `rd_data` is valid.
- `rd_data`  out  DATA_W: current weight.
- `rd_last`  out  1: `rd_data` is the last weight of its row.
- `row_idx`  out  clog2(NUM_ROWS), min 1: index of the row being read, 0..NUM_ROWS-1.
- `layer_done`  out  1: one-cycle pulse after the final weight of the pass is read.
- `busy`  out  1: high from the edge after `start` until `layer_done`.

## Operation
- Storage: two banks of `ROW_LEN` × `DATA_W` registers, with `bank_full[1:0]`, `wr_bank`, `rd_bank`, `wr_ptr` and `rd_ptr`.
- Counters are each clog2(NUM_ROWS+1) bits: `rows_req`, `rows_loaded` and `rows_read`.
- FSM has two states, IDLE and RUN.
  - IDLE → RUN when `start` is high. This clears all counters and pointers, zeroes both `bank_full` bits, and sets both bank selects to 0.
  - RUN → IDLE on the edge that consumes the last weight of row NUM_ROWS-1.
- Request rule: on any edge in RUN where `rows_req < NUM_ROWS`, `rows_req == rows_loaded` and `!bank_full[wr_bank]`, the block sets `load_next_row`=1 for one cycle and increments `rows_req`.
- Write rule:
  - `w_ready` = RUN && `rows_loaded < rows_req` && `!bank_full[wr_bank]`.
  - Each accepted word (`w_valid && w_ready`) is written at `wr_ptr`, then `wr_ptr` increments.
  - At `wr_ptr == ROW_LEN-1`, the block sets `bank_full[wr_bank]`, toggles `wr_bank`, zeroes `wr_ptr` and increments `rows_loaded`.
- Read rule:
  - `rd_valid` = `bank_full[rd_bank]`.
  - `rd_data` = `bank[rd_bank][rd_ptr]`, combinational from registers.
  - `rd_last` = `rd_valid && rd_ptr == ROW_LEN-1`.
  - `row_idx` = `rows_read`.
  - On `rd_en && rd_valid`, `rd_ptr` increments. On the last word, the block clears `bank_full[rd_bank]`, toggles `rd_bank`, zeroes `rd_ptr` and increments `rows_read`.
  - `rd_en` while `!rd_valid` is ignored.
- Simultaneous events:
  - A write that fills one bank and a read that frees the other bank in the same edge both take effect.
  - A request is then evaluated on the following edge, so at most one `load_next_row` pulse is outstanding.
- `start` while busy is ignored.
- Words presented while `w_ready` is low are not consumed. The host holds them.

## Timing
- Reset values: `w_ready`=0, `load_next_row`=0, `rd_valid`=0, `rd_last`=0, `row_idx`=0, `layer_done`=0, `busy`=0, state IDLE.
- `rd_data` is undefined after reset; bank contents are not reset.
- Start sequence: edge E0 samples `start` and enters RUN, raising `busy`. `load_next_row` is high after E1 and low after E2. `w_ready` rises after E1.
- Load-to-read latency: the edge accepting the last word of a row raises `rd_valid` immediately after that edge, with 1 cycle of latency.
- Next request: one edge after the write bank is seen empty with no request outstanding. This is E+1 after row 0 fills, because bank 1 is free.
- `layer_done` is high for exactly one cycle after the edge consuming the final weight. `busy` falls on that same edge.
- Reset mid-pass: all outputs and counters return to reset values asynchronously, and no `layer_done` is issued.

## Test plan
Tests use `ROW_LEN`=4, `NUM_ROWS`=3 and `DATA_W`=16.

- Basic pass: `start`, then the host answers each request with words 0x0001..0x000C and the consumer holds `rd_en`=1. Required: exactly 3 `load_next_row` pulses; `rd_data` sequence 1..12; `rd_last` on 4, 8 and 12; `row_idx` 0,0,0,0,1,…,2; one `layer_done`; `busy` falls.
- Overlap: the consumer stalls (`rd_en`=0) after row 0 loads. Required: row 1 loads into bank 1; then `w_ready`=0 and no third request until row 0 is fully read.
- Backpressure: `w_valid` held high from reset with word 0xAAAA before any request. Required: `w_ready`=0 and no write until after E1; the first read word is 0xAAAA.
- Simultaneous fill and free: the fourth word of row 1 is written on the same edge that row 0's last word is read. Required: both banks update correctly and a single `load_next_row` pulse occurs for row 2 on the next edge.
- Reset mid-pass: `reset` is driven low while `rd_ptr`=2 in row 1. Required: all outputs zero immediately; a new `start` replays from row 0 with fresh requests.
- Ignored inputs: `start` pulsed mid-pass and `rd_en` asserted with `rd_valid`=0. Required: no state change, no pointer movement and no extra pulses.
